// File: rtl/gshare_bp_pkg.sv
// Shared types and helpers for the gshare branch predictor: FSM state,
// saturating-counter update and init value.
package bp_types;

  typedef enum logic {BP_INIT, BP_RUN} bp_state_e;

  // Widest counter supported; helpers work at this width and callers narrow.
  localparam int CTR_MAX_W = 4;

  function automatic logic [CTR_MAX_W-1:0] weak_nt_val(input int ctr_w);
    return CTR_MAX_W'((1 << (ctr_w - 1)) - 1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_ctr_next(
    input logic [CTR_MAX_W-1:0] ctr,
    input logic                 taken,
    input int                   ctr_w
  );
    logic [CTR_MAX_W-1:0] max_val;
    max_val = CTR_MAX_W'((1 << ctr_w) - 1);
    if (taken) begin
      return (ctr == max_val) ? ctr : ctr + CTR_MAX_W'(1);
    end
    return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
  endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: counter storage cleared by a one-entry-per-cycle
// sweep, one async read port and one read-modify-write update port.
module gshare_pht
  import bp_types::*;
#(
  parameter int IDX_W = 10,
  parameter int CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken,
  output logic             ready
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] INIT_VAL = CTR_W'(weak_nt_val(CTR_W));

  logic [CTR_W-1:0] mem [DEPTH];

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic             ready_q, ready_d;
  logic [CTR_W-1:0] wr_cur;
  logic [CTR_W-1:0] wr_next;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [CTR_W-1:0] mem_wdata;

  assign ready   = ready_q;
  assign rd_ctr  = mem[rd_idx];
  assign wr_cur  = mem[wr_idx];
  assign wr_next = CTR_W'(sat_ctr_next(CTR_MAX_W'(wr_cur), wr_taken, CTR_W));

  // The sweep owns the write port until the last entry is written.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_idx;
    mem_wdata  = wr_next;
    if (state_q == BP_INIT) begin
      mem_we     = 1'b1;
      mem_waddr  = init_idx_q;
      mem_wdata  = INIT_VAL;
      init_idx_d = init_idx_q + IDX_W'(1);
      if (init_idx_q == IDX_W'(DEPTH - 1)) begin
        state_d = BP_RUN;
      end
    end else if (wr_en) begin
      mem_we = 1'b1;
    end
    ready_d = (state_d == BP_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BP_INIT;
      init_idx_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ready_q    <= ready_d;
    end
  end

  // No reset on the array so it can map onto RAM; the sweep clears it.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: rtl/gshare_bp.sv
// gshare predictor top: PC/GHR index hashing, speculative GHR with mispredict
// repair, optional statistics counters enabled by GSHARE_BP_STATS_EN.
module gshare_bp
  import bp_types::*;
#(
  parameter int PC_IDX_W  = 10,
  parameter int PC_OFFSET = 2,
  parameter int HIST_W    = 8,
  parameter int CTR_W     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ready,
  input  logic              pred_valid,
  input  logic [31:0]       pred_pc,
  output logic              pred_take,
  output logic [HIST_W-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [HIST_W-1:0] upd_ghr,
  input  logic              upd_taken,
  input  logic              upd_mispredict
`ifdef GSHARE_BP_STATS_EN
  ,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_updates,
  output logic [31:0]       stat_mispredicts
`endif
);

  if (HIST_W < 2 || HIST_W > PC_IDX_W) begin : g_bad_hist_w
    $error("gshare_bp: HIST_W must be in 2..PC_IDX_W");
  end
  if (CTR_W < 1 || CTR_W > CTR_MAX_W) begin : g_bad_ctr_w
    $error("gshare_bp: CTR_W must be in 1..4");
  end

  logic [HIST_W-1:0]   ghr_q, ghr_d;
  logic [PC_IDX_W-1:0] pred_idx;
  logic [PC_IDX_W-1:0] upd_idx;
  logic [CTR_W-1:0]    pred_ctr;
  logic                unused_pc_bits;

  assign pred_idx = pred_pc[PC_IDX_W+PC_OFFSET-1:PC_OFFSET] ^ PC_IDX_W'(ghr_q);
  assign upd_idx  = upd_pc[PC_IDX_W+PC_OFFSET-1:PC_OFFSET] ^ PC_IDX_W'(upd_ghr);
  assign unused_pc_bits = ^{pred_pc, upd_pc};

  gshare_pht #(
    .IDX_W (PC_IDX_W),
    .CTR_W (CTR_W)
  ) u_pht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (pred_idx),
    .rd_ctr   (pred_ctr),
    .wr_en    (upd_valid && ready),
    .wr_idx   (upd_idx),
    .wr_taken (upd_taken),
    .ready    (ready)
  );

  assign pred_take = ready ? pred_ctr[CTR_W-1] : 1'b0;
  assign pred_ghr  = ghr_q;

  // Repair from EX overrides this cycle's speculative shift.
  always_comb begin
    ghr_d = ghr_q;
    if (ready) begin
      if (upd_valid && upd_mispredict) begin
        ghr_d = {upd_ghr[HIST_W-2:0], upd_taken};
      end else if (pred_valid) begin
        ghr_d = {ghr_q[HIST_W-2:0], pred_take};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

`ifdef GSHARE_BP_STATS_EN
  logic [31:0] lookups_q, lookups_d;
  logic [31:0] updates_q, updates_d;
  logic [31:0] mispredicts_q, mispredicts_d;

  always_comb begin
    lookups_d     = lookups_q;
    updates_d     = updates_q;
    mispredicts_d = mispredicts_q;
    if (ready) begin
      if (pred_valid)                      lookups_d     = lookups_q + 32'd1;
      if (upd_valid)                       updates_d     = updates_q + 32'd1;
      if (upd_valid && upd_mispredict)     mispredicts_d = mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lookups_q     <= '0;
      updates_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      lookups_q     <= lookups_d;
      updates_q     <= updates_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_updates     = updates_q;
  assign stat_mispredicts = mispredicts_q;
`endif

endmodule
